wb_tlc_cpld_txbuf: RTL and testbench



---
 rtl/wb_tlc_cpld_txbuf.sv | 263 ++++++++++++++++++++++++++
 tb/tb_wb_tlc_cpld_txbuf.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_tlc_cpld_txbuf.sv
// -----------------------------------------------------------------------------
// wb_tlc_cpld_txbuf
//
// Store-and-forward buffer between the read-completion builder and the PCIe
// core transmit port. Incoming TLP words are held until the packet's last word
// has been written. The packet is then committed, the transmit port is
// requested, and the packet is replayed contiguously. A packet that cannot
// fit is dropped whole. A partial packet is never forwarded.
//
// Ports
//   wb_clk     clock, all registers update on the rising edge
//   rst        synchronous active-high reset, empties the buffer
//   din        16-bit TLP word from the completion builder
//   din_sop    first word of a packet (qualified by din_wen)
//   din_eop    last word of a packet (qualified by din_wen)
//   din_wen    word valid, no backpressure
//   tx_req     request to the transmit port
//   tx_rdy     grant from the transmit port
//   tx_data    outgoing word
//   tx_val     tx_data valid
//   tx_st      first word of the outgoing packet
//   tx_end     last word of the outgoing packet
//   pkt_cnt    number of complete packets stored
//   drop       one-cycle pulse when a packet is discarded
//   proto_err  one-cycle pulse on illegal input framing
// -----------------------------------------------------------------------------
module wb_tlc_cpld_txbuf #(
   parameter int DEPTH_LOG2 = 8,
   parameter int MAX_PKT    = 70
) (
   input  logic                wb_clk,
   input  logic                rst,
   input  logic [15:0]         din,
   input  logic                din_sop,
   input  logic                din_eop,
   input  logic                din_wen,
   output logic                tx_req,
   input  logic                tx_rdy,
   output logic [15:0]         tx_data,
   output logic                tx_val,
   output logic                tx_st,
   output logic                tx_end,
   output logic [DEPTH_LOG2:0] pkt_cnt,
   output logic                drop,
   output logic                proto_err
);

   localparam int                  DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] LP_DEPTH = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] LP_MAX   = (DEPTH_LOG2+1)'(MAX_PKT);

   localparam logic [1:0] WIDLE = 2'd0;
   localparam logic [1:0] WPKT  = 2'd1;
   localparam logic [1:0] WDROP = 2'd2;

   localparam logic [1:0] RIDLE = 2'd0;
   localparam logic [1:0] RREQ  = 2'd1;
   localparam logic [1:0] RSEND = 2'd2;

   // Storage entry is {eop, data}
   logic [16:0]           r_mem [0:DEPTH-1];

   logic [DEPTH_LOG2:0]   r_wr_ptr;
   logic [DEPTH_LOG2:0]   r_commit_ptr;
   logic [DEPTH_LOG2:0]   r_rd_ptr;
   logic [1:0]            r_wstate;
   logic [1:0]            r_rstate;
   logic [DEPTH_LOG2:0]   r_pkt_cnt;
   logic                  r_drop;
   logic                  r_perr;
   logic                  r_tx_req;
   logic                  r_tx_val;
   logic                  r_tx_st;
   logic                  r_tx_end;
   logic [15:0]           r_tx_data;

   logic [DEPTH_LOG2:0]   w_free_wr;
   logic [DEPTH_LOG2:0]   w_free_sop;
   logic                  w_we;
   logic [DEPTH_LOG2:0]   w_waddr;
   logic [DEPTH_LOG2:0]   w_wr_ptr_nxt;
   logic [DEPTH_LOG2:0]   w_commit_ptr_nxt;
   logic [1:0]            w_wstate_nxt;
   logic                  w_commit;
   logic                  w_drop;
   logic                  w_perr;
   logic                  w_tx_done;
   logic [16:0]           w_rd_word;

   // Free space as seen by the current write pointer (continuing a packet)
   // and by the commit pointer (a sop always restarts from the last commit,
   // which discards any fragment still in progress).
   assign w_free_wr  = LP_DEPTH - (r_wr_ptr - r_rd_ptr);
   assign w_free_sop = LP_DEPTH - (r_commit_ptr - r_rd_ptr);

   assign w_rd_word  = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
   assign w_tx_done  = (r_rstate == RSEND) && r_tx_end;

   // ---------------------------------------------------------------- write side
   always_comb begin
      w_we             = 1'b0;
      w_waddr          = r_wr_ptr;
      w_wr_ptr_nxt     = r_wr_ptr;
      w_commit_ptr_nxt = r_commit_ptr;
      w_wstate_nxt     = r_wstate;
      w_commit         = 1'b0;
      w_drop           = 1'b0;
      w_perr           = 1'b0;

      if (din_wen) begin
         if (din_sop) begin
            // A sop outside WIDLE abandons the current packet or drop run.
            if (r_wstate != WIDLE) begin
               w_perr = 1'b1;
            end
            w_wr_ptr_nxt = r_commit_ptr;
            if (w_free_sop >= LP_MAX) begin
               w_we         = 1'b1;
               w_waddr      = r_commit_ptr;
               w_wr_ptr_nxt = r_commit_ptr + 1'b1;
               if (din_eop) begin
                  w_commit_ptr_nxt = r_commit_ptr + 1'b1;
                  w_commit         = 1'b1;
                  w_wstate_nxt     = WIDLE;
               end else begin
                  w_wstate_nxt = WPKT;
               end
            end else begin
               w_drop       = 1'b1;
               // A rejected single-word packet leaves nothing to discard.
               w_wstate_nxt = din_eop ? WIDLE : WDROP;
            end
         end else begin
            case (r_wstate)
               WIDLE: begin
                  w_perr = 1'b1;
               end
               WPKT: begin
                  if (w_free_wr == '0) begin
                     w_wr_ptr_nxt = r_commit_ptr;
                     w_drop       = 1'b1;
                     w_wstate_nxt = din_eop ? WIDLE : WDROP;
                  end else begin
                     w_we         = 1'b1;
                     w_waddr      = r_wr_ptr;
                     w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                     if (din_eop) begin
                        w_commit_ptr_nxt = r_wr_ptr + 1'b1;
                        w_commit         = 1'b1;
                        w_wstate_nxt     = WIDLE;
                     end
                  end
               end
               WDROP: begin
                  if (din_eop) begin
                     w_wstate_nxt = WIDLE;
                  end
               end
               default: begin
                  w_wstate_nxt = WIDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge wb_clk) begin
      if (w_we) begin
         r_mem[w_waddr[DEPTH_LOG2-1:0]] <= {din_eop, din};
      end
   end

   always_ff @(posedge wb_clk) begin
      if (rst) begin
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_wstate     <= WIDLE;
         r_drop       <= 1'b0;
         r_perr       <= 1'b0;
      end else begin
         r_wr_ptr     <= w_wr_ptr_nxt;
         r_commit_ptr <= w_commit_ptr_nxt;
         r_wstate     <= w_wstate_nxt;
         r_drop       <= w_drop;
         r_perr       <= w_perr;
      end
   end

   // ---------------------------------------------------------------- packet count
   always_ff @(posedge wb_clk) begin
      if (rst) begin
         r_pkt_cnt <= '0;
      end else begin
         case ({w_commit, w_tx_done})
            2'b10:   r_pkt_cnt <= r_pkt_cnt + 1'b1;
            2'b01:   r_pkt_cnt <= r_pkt_cnt - 1'b1;
            default: r_pkt_cnt <= r_pkt_cnt;
         endcase
      end
   end

   // ---------------------------------------------------------------- read side
   // tx_data is the registered RAM read. The grant edge loads the first word
   // straight from the committed head, so data follows the grant without a
   // bubble. The decrement of pkt_cnt happens on the edge that retires the
   // tx_end word, so RIDLE always sees an up-to-date count.
   always_ff @(posedge wb_clk) begin
      if (rst) begin
         r_rstate  <= RIDLE;
         r_rd_ptr  <= '0;
         r_tx_req  <= 1'b0;
         r_tx_val  <= 1'b0;
         r_tx_st   <= 1'b0;
         r_tx_end  <= 1'b0;
         r_tx_data <= '0;
      end else begin
         case (r_rstate)
            RIDLE: begin
               if (r_pkt_cnt != '0) begin
                  r_rstate <= RREQ;
                  r_tx_req <= 1'b1;
               end
            end
            RREQ: begin
               if (tx_rdy) begin
                  r_rstate  <= RSEND;
                  r_tx_req  <= 1'b0;
                  r_tx_val  <= 1'b1;
                  r_tx_st   <= 1'b1;
                  r_tx_data <= w_rd_word[15:0];
                  r_tx_end  <= w_rd_word[16];
                  r_rd_ptr  <= r_rd_ptr + 1'b1;
               end
            end
            RSEND: begin
               r_tx_st <= 1'b0;
               if (r_tx_end) begin
                  r_rstate <= RIDLE;
                  r_tx_val <= 1'b0;
                  r_tx_end <= 1'b0;
               end else begin
                  r_tx_data <= w_rd_word[15:0];
                  r_tx_end  <= w_rd_word[16];
                  r_rd_ptr  <= r_rd_ptr + 1'b1;
               end
            end
            default: begin
               r_rstate <= RIDLE;
            end
         endcase
      end
   end

   assign tx_req    = r_tx_req;
   assign tx_data   = r_tx_data;
   assign tx_val    = r_tx_val;
   assign tx_st     = r_tx_st;
   assign tx_end    = r_tx_end;
   assign pkt_cnt   = r_pkt_cnt;
   assign drop      = r_drop;
   assign proto_err = r_perr;

endmodule

// File: tb/tb_wb_tlc_cpld_txbuf.sv
// -----------------------------------------------------------------------------
// Testbench for wb_tlc_cpld_txbuf: scoreboard of expected transmit words plus
// a vector table for input framing and hand-written multi-cycle sequences.
// -----------------------------------------------------------------------------
module tb_wb_tlc_cpld_txbuf;

   typedef struct {
      logic        sop;
      logic        eop;
      logic        wen;
      logic [15:0] data;
      logic        exp_drop;
      logic        exp_perr;
      logic        push;
   } vec_t;

   typedef struct {
      logic [15:0] data;
      logic        st;
      logic        en;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] din = '0;
   logic        din_sop = 1'b0;
   logic        din_eop = 1'b0;
   logic        din_wen = 1'b0;
   logic        tx_rdy = 1'b0;
   logic        tx_req;
   logic [15:0] tx_data;
   logic        tx_val;
   logic        tx_st;
   logic        tx_end;
   logic [8:0]  pkt_cnt;
   logic        drop;
   logic        proto_err;

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sbq[$];
   logic sb_off = 1'b0;
   logic in_pkt = 1'b0;
   vec_t vecs[13];

   wb_tlc_cpld_txbuf #(.DEPTH_LOG2(8), .MAX_PKT(70)) dut (
      .wb_clk    (clk),
      .rst       (rst),
      .din       (din),
      .din_sop   (din_sop),
      .din_eop   (din_eop),
      .din_wen   (din_wen),
      .tx_req    (tx_req),
      .tx_rdy    (tx_rdy),
      .tx_data   (tx_data),
      .tx_val    (tx_val),
      .tx_st     (tx_st),
      .tx_end    (tx_end),
      .pkt_cnt   (pkt_cnt),
      .drop      (drop),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic e, input logic w, input logic [15:0] d);
      din_sop = s;
      din_eop = e;
      din_wen = w;
      din     = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 16'h0000);
   endtask

   task automatic push_exp(input logic [15:0] d, input logic s, input logic e);
      exp_t x;
      x.data = d;
      x.st   = s;
      x.en   = e;
      sbq.push_back(x);
   endtask

   // Sends a len-word packet whose words are base+i, optionally expected out.
   task automatic send_pkt(input int len, input logic [15:0] base, input logic expect_out);
      for (int i = 0; i < len; i++) begin
         if (expect_out) push_exp(base + 16'(i), i == 0, i == len - 1);
         drive(i == 0, i == len - 1, 1'b1, base + 16'(i));
      end
   endtask

   task automatic wait_drain(input int maxc, input string name);
      int c;
      c = 0;
      while ((sbq.size() != 0 || tx_val || pkt_cnt != 0) && c < maxc) begin
         idle();
         c++;
      end
      chk({name, "_queue_left"}, sbq.size(), 0);
      chk({name, "_pkt_cnt"}, {23'd0, pkt_cnt}, 0);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_tx_req"},    {31'd0, tx_req}, 0);
      chk({name, "_tx_val"},    {31'd0, tx_val}, 0);
      chk({name, "_tx_st"},     {31'd0, tx_st}, 0);
      chk({name, "_tx_end"},    {31'd0, tx_end}, 0);
      chk({name, "_tx_data"},   {16'd0, tx_data}, 0);
      chk({name, "_pkt_cnt"},   {23'd0, pkt_cnt}, 0);
      chk({name, "_drop"},      {31'd0, drop}, 0);
      chk({name, "_proto_err"}, {31'd0, proto_err}, 0);
   endtask

   // Transmit monitor: every valid word must match the head of the scoreboard
   // and a packet must not have gaps between tx_st and tx_end.
   always @(negedge clk) begin
      exp_t e;
      if (sb_off) begin
         in_pkt = 1'b0;
      end else begin
         if (in_pkt) begin
            n_chk++;
            if (!tx_val) begin
               n_fail++;
               $display("FAIL tx_gap: tx_val=0 inside a packet, required 1");
            end
         end
         if (tx_val) begin
            if (sbq.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL tx_unexpected: got word %h st=%b end=%b, required no word", tx_data, tx_st, tx_end);
            end else begin
               e = sbq.pop_front();
               chk("tx_data", {16'd0, tx_data}, {16'd0, e.data});
               chk("tx_st",   {31'd0, tx_st},   {31'd0, e.st});
               chk("tx_end",  {31'd0, tx_end},  {31'd0, e.en});
            end
            if (tx_st)  in_pkt = 1'b1;
            if (tx_end) in_pkt = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;

      // framing vectors: stray word, aborted fragment, resumed packet, 1-word packet
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 16'hdead, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 16'h1002, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h1003, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h2000, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 16'h2001, 1'b0, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h2002, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 16'h2003, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 16'h3000, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};

      // reset state
      rst = 1'b1;
      idle();
      idle();
      chk_all_zero("reset");
      rst = 1'b0;
      idle();

      // single 8-word packet with tx_rdy held high
      tx_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         push_exp((i == 0) ? 16'h4a00 : 16'(i), i == 0, i == 7);
         drive(i == 0, i == 7, 1'b1, (i == 0) ? 16'h4a00 : 16'(i));
      end
      chk("t1_pkt_cnt_after_eop", {23'd0, pkt_cnt}, 1);
      chk("t1_req_t1", {31'd0, tx_req}, 0);
      idle();
      chk("t1_req_t2", {31'd0, tx_req}, 1);
      chk("t1_val_t2", {31'd0, tx_val}, 0);
      idle();
      chk("t1_req_after_grant", {31'd0, tx_req}, 0);
      chk("t1_first_val", {31'd0, tx_val}, 1);
      for (int i = 1; i < 8; i++) begin
         idle();
         chk("t1_val_run", {31'd0, tx_val}, 1);
      end
      idle();
      chk("t1_val_after", {31'd0, tx_val}, 0);
      chk("t1_pkt_cnt_end", {23'd0, pkt_cnt}, 0);

      // three 70-word packets fill the buffer; the fourth is dropped
      tx_rdy = 1'b0;
      for (int k = 0; k < 3; k++) send_pkt(70, {4'(k + 1), 12'h000}, 1'b1);
      chk("t2_pkt_cnt3", {23'd0, pkt_cnt}, 3);
      chk("t2_req", {31'd0, tx_req}, 1);
      for (int i = 0; i < 70; i++) begin
         drive(i == 0, i == 69, 1'b1, 16'h4000 + 16'(i));
         chk("t2_drop", {31'd0, drop}, (i == 0) ? 32'd1 : 32'd0);
      end
      chk("t2_pkt_cnt_after_drop", {23'd0, pkt_cnt}, 3);

      // release the transmit port: three packets replayed in order
      tx_rdy = 1'b1;
      wait_drain(400, "t3_drain");

      // framing table
      for (int v = 0; v < 13; v++) begin
         if (vecs[v].push) push_exp(vecs[v].data, vecs[v].sop, vecs[v].eop);
         drive(vecs[v].sop, vecs[v].eop, vecs[v].wen, vecs[v].data);
         chk("tbl_drop", {31'd0, drop}, {31'd0, vecs[v].exp_drop});
         chk("tbl_proto_err", {31'd0, proto_err}, {31'd0, vecs[v].exp_perr});
      end
      wait_drain(50, "tbl_drain");

      // commit of B on the same edge that retires the tx_end of A
      tx_rdy = 1'b0;
      send_pkt(4, 16'h6000, 1'b1);
      idle();
      chk("cc_req", {31'd0, tx_req}, 1);
      tx_rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push_exp(16'h7000 + 16'(i), i == 0, i == 4);
         drive(i == 0, i == 4, 1'b1, 16'h7000 + 16'(i));
         if (i == 3) begin
            chk("cc_tx_end_A", {31'd0, tx_end}, 1);
            chk("cc_pkt_cnt_before", {23'd0, pkt_cnt}, 1);
         end
      end
      chk("cc_pkt_cnt_same", {23'd0, pkt_cnt}, 1);
      chk("cc_val_after_A", {31'd0, tx_val}, 0);
      wait_drain(50, "cc_drain");

      // reset in the middle of a transmit and of a write
      tx_rdy = 1'b0;
      sb_off = 1'b1;
      send_pkt(20, 16'h8000, 1'b0);
      for (int i = 0; i < 4; i++) drive(i == 0, 1'b0, 1'b1, 16'h9000 + 16'(i));
      tx_rdy = 1'b1;
      c = 0;
      while (!tx_val && c < 10) begin
         idle();
         c++;
      end
      chk("rst_tx_started", {31'd0, tx_val}, 1);
      idle();
      idle();
      idle();
      rst = 1'b1;
      idle();
      rst = 1'b0;
      chk_all_zero("midrst");
      sb_off = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 16'h9004);
      chk("rst_wr_abandoned", {31'd0, proto_err}, 1);
      drive(1'b0, 1'b1, 1'b1, 16'h9005);
      for (int i = 0; i < 30; i++) idle();
      chk("rst_pkt_cnt", {23'd0, pkt_cnt}, 0);
      chk("rst_req", {31'd0, tx_req}, 0);

      // buffer is usable again after reset
      send_pkt(5, 16'ha000, 1'b1);
      wait_drain(50, "post_rst_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
